// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory port arbiter: ownership-state
//   encoding, response owner tags and the starvation counter width.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DBG_LOCK = 2'd1,
    ST_FORCE    = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// arb_starve_counter
//   Saturating counter of consecutive denied dbg cycles.
//   Ports:
//     clock, resetn   - system clock, asynchronous active-low reset
//     inc             - dbg requested but was not granted this cycle
//     clr             - dbg granted or not requesting; wins over inc
//     at_limit_next   - the value loaded at the next edge has reached LIMIT
module arb_starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic at_limit_next
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // The limit flag looks at the upcoming value so the arbiter can switch
  // ownership in the very cycle after the limit is reached.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count < LIM)) begin
      count_next = count + CNT_W'(1);
    end
  end

  assign at_limit_next = (count_next >= LIM);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory/I/O port between the pipeline MEM stage
//   (cpu) and a debug/loader port (dbg). One access per cycle; cpu has
//   priority unless dbg holds a lock or has been starved for STARVE_MAX
//   cycles. Read data comes back one cycle after the grant, tagged to the
//   requester that owned the access.
//   Ports:
//     clock, resetn                          - clock, async active-low reset
//     cpu_req/we/addr/wdata                  - cpu request side
//     cpu_stall                              - cpu requesting but not granted
//     cpu_rvalid/cpu_rdata                   - cpu read response
//     dbg_req/lock/we/addr/wdata             - dbg request side
//     dbg_gnt                                - dbg access performed this cycle
//     dbg_rvalid/dbg_rdata                   - dbg read response
//     mem_addr/mem_wdata/mem_we/mem_rdata    - memory/I/O wrapper interface
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_lock,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e state;
  arb_state_e state_next;
  logic       cpu_gnt;
  logic       dbg_first;
  logic       starve_hit;
  logic       rsp_valid;
  logic       rsp_owner;

  arb_starve_counter #(
    .LIMIT(STARVE_MAX)
  ) u_starve (
    .clock        (clock),
    .resetn       (resetn),
    .inc          (dbg_req & ~dbg_gnt),
    .clr          (dbg_gnt | ~dbg_req),
    .at_limit_next(starve_hit)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision. A held lock or a forced turn only gives dbg priority
  // while it is actually requesting; otherwise plain cpu-first rules apply.
  // Grants are suppressed while reset is held so nothing reaches memory.
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    dbg_first = 1'b0;
    case (state)
      ST_DBG_LOCK, ST_FORCE: dbg_first = 1'b1;
      default:               dbg_first = 1'b0;
    endcase
    if (resetn) begin
      if (dbg_req && (dbg_first || !cpu_req)) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  // Next owner: a locked dbg grant keeps ownership, otherwise a starved
  // dbg gets the following cycle.
  always_comb begin
    state_next = ST_IDLE;
    if (dbg_gnt && dbg_lock) begin
      state_next = ST_DBG_LOCK;
    end else if (starve_hit) begin
      state_next = ST_FORCE;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt & resetn;

  // Memory drive: idle cycles present all-zero so the wrapper never sees
  // a stray write strobe or address.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Response tag: remembers who issued a read so the data returned by the
  // wrapper next cycle is steered to the right requester.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_owner <= OWN_CPU;
    end else begin
      rsp_valid <= (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);
      rsp_owner <= dbg_gnt ? OWN_DBG : OWN_CPU;
    end
  end

  assign cpu_rvalid = rsp_valid & (rsp_owner == OWN_CPU);
  assign dbg_rvalid = rsp_valid & (rsp_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/I/O port (data RAM below addr[7]=0, I/O registers at addr[7]=1) between two requesters: the pipeline MEM stage (cpu) and a debug/loader port (dbg).
- Sits directly above the data-memory/I/O wrapper and drives its addr, datain and we inputs.
- Performs one access per cycle with a registered owner, fixed cpu priority, a starvation guarantee for dbg, and dbg locked bursts.
- Read data is returned one cycle after grant, tagged to the requester that owned the access.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, maximum consecutive denied dbg cycles before dbg is forced a grant (range 1..15)

Ports:
- clock  in  1  single system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- cpu_req  in  1  cpu access request, level, held until granted
- cpu_we  in  1  cpu write when 1, read when 0
- cpu_addr  in  AW  cpu byte address
- cpu_wdata  in  DW  cpu write data
- cpu_stall  out  1  combinational: cpu_req & ~cpu_gnt; pipeline freezes while 1
- cpu_rvalid  out  1  registered: cpu read data valid
- cpu_rdata  out  DW  cpu read data
- dbg_req  in  1  dbg access request, level
- dbg_lock  in  1  sampled with dbg_req; keeps ownership for the next access
- dbg_we  in  1  dbg write when 1
- dbg_addr  in  AW  dbg byte address
- dbg_wdata  in  DW  dbg write data
- dbg_gnt  out  1  combinational: dbg access performed this cycle
- dbg_rvalid  out  1  registered: dbg read data valid
- dbg_rdata  out  DW  dbg read data
- mem_addr  out  AW  to memory/I/O wrapper addr
- mem_wdata  out  DW  to memory/I/O wrapper datain
- mem_we  out  1  to memory/I/O wrapper we
- mem_rdata  in  DW  from memory/I/O wrapper dataout, valid the cycle after the address

Behaviour:
- FSM (owner of the current cycle) has three states:
  - IDLE: no lock held.
  - DBG_LOCK: dbg holds ownership.
  - FORCE: starvation limit reached.
- Grant decision (combinational, from state and requests):
  - DBG_LOCK: dbg_req=1 grants dbg; cpu is stalled. dbg_req=0 releases the lock immediately and re-arbitrates as IDLE in the same cycle.
  - FORCE: dbg is granted if dbg_req=1, otherwise falls back to IDLE rules.
  - IDLE: cpu_req wins over dbg_req; dbg is granted only when cpu_req=0.
- Next state:
  - dbg granted with dbg_lock=1 -> DBG_LOCK.
  - Otherwise, starve_cnt reaching STARVE_MAX -> FORCE.
  - Otherwise -> IDLE.
- starve_cnt (4 bits):
  - Increments each cycle dbg_req=1 and dbg is not granted, saturating at STARVE_MAX.
  - Clears on any dbg grant or when dbg_req=0.
- Memory drive:
  - The granted requester's addr, wdata and we are muxed to mem_*.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_we is never 1 without a grant.
- Read response:
  - A read grant in cycle N sets rsp_owner and rsp_valid, registered at the end of cycle N.
  - In cycle N+1, the owner's *_rvalid=1 and *_rdata = mem_rdata (pass-through).
  - The non-owner's rdata is held at 0.
  - Writes produce no rvalid.
- Back-to-back: a new grant in cycle N+1 is legal while the cycle-N response is returned; responses never overlap for the same owner.
- Simultaneous cpu_req and dbg_req in IDLE: cpu wins, dbg counts toward starvation.
- Reset (resetn=0, asynchronous):
  - State is IDLE; starve_cnt=0; rsp_valid=0.
  - cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0.
  - mem_we=0; dbg_gnt=0 and cpu_stall=0 while held in reset.
- Reset mid-burst: the lock and any pending response are dropped, with no rvalid after release.
- Address decoding (RAM vs I/O) is not done here; the arbiter is address-agnostic.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_DBG_LOCK=2'd1, ST_FORCE=2'd2
  - owner tags: OWN_CPU=1'b0, OWN_DBG=1'b1
- One natural sub-module: arb_starve_counter (saturating counter with clear, limit parameter).

Test Plan:
- Reset, then cpu read of addr 0x00000004 holding 0x12345678 -> cpu_stall=0, mem_we=0, next cycle cpu_rvalid=1, cpu_rdata=0x12345678, dbg_rvalid=0.
- cpu_req and dbg_req both high continuously, STARVE_MAX=4 -> cpu granted 4 cycles, dbg granted on the 5th with cpu_stall=1 for exactly that cycle, then the pattern repeats.
- dbg writes 0xA5 to 0x80 then 0x84 with dbg_lock=1 while cpu_req=1 -> cpu_stall=1 for both cycles, mem_we=1 with dbg data; cpu is granted the cycle dbg_req drops.
- Alternating grants: cpu read 0x08, then dbg read 0x0C -> cpu_rvalid in cycle 2, dbg_rvalid in cycle 3, each with the correct word and no cross-tagging.
- Assert resetn=0 during a dbg locked burst with a read pending -> all rvalid=0 immediately, state IDLE, cpu is granted on the first request after release.
- No requests -> mem_we=0, mem_addr=0, no rvalid, starve_cnt stays 0.
